// File: rtl/div_by_shift_sum_if.sv
// Operand/result bundle for the iterative shift-and-subtract divider.
// The remainder signal exists only when DIV_BY_SHIFT_SUM_REMAINDER_EN is defined.
interface div_by_shift_sum_if #(
    parameter int WidthD0 = 8,
    parameter int WidthD1 = 4
);
    logic               start;
    logic [WidthD0-1:0] a;
    logic [WidthD1-1:0] b;
    logic [WidthD0-1:0] result;
    logic               valid;
`ifdef DIV_BY_SHIFT_SUM_REMAINDER_EN
    logic [WidthD1-1:0] remainder;
`endif

    modport master (
        output start, a, b,
        input  result, valid
`ifdef DIV_BY_SHIFT_SUM_REMAINDER_EN
        , input remainder
`endif
    );

    modport slave (
        input  start, a, b,
        output result, valid
`ifdef DIV_BY_SHIFT_SUM_REMAINDER_EN
        , output remainder
`endif
    );
endinterface

// File: rtl/div_by_shift_sum.sv
// Restoring shift-and-subtract unsigned divider, one quotient bit per clock.
// Optional remainder output: define DIV_BY_SHIFT_SUM_REMAINDER_EN.
module div_by_shift_sum #(
    parameter int WidthD0 = 8,
    parameter int WidthD1 = 4
) (
    input  logic                clk,
    input  logic                rst,
    div_by_shift_sum_if.slave   bus
);
    localparam int CntW = $clog2(WidthD0 + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_nxt;
    logic [CntW-1:0]    cnt;
    logic [WidthD0-1:0] dvd, quo, quo_nxt;
    logic [WidthD1-1:0] dvs;
    logic [WidthD1:0]   rem, rem_sh, rem_nxt;
    logic               q_bit, step, last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.start) begin
            state_nxt = BUSY;
        end else begin
            case (state)
                BUSY:    if (cnt == CntW'(1)) state_nxt = DONE;
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        step = (state == BUSY) && !bus.start;
        last = step && (cnt == CntW'(1));
    end

    // Remainder is one bit wider than the divisor so a zero divisor just
    // keeps accumulating dividend bits instead of needing a special case.
    always_comb begin
        rem_sh  = {rem[WidthD1-1:0], dvd[WidthD0-1]};
        q_bit   = (rem_sh >= {1'b0, dvs});
        rem_nxt = q_bit ? (rem_sh - {1'b0, dvs}) : rem_sh;
        quo_nxt = {quo[WidthD0-2:0], q_bit};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dvd        <= '0;
            dvs        <= '0;
            rem        <= '0;
            quo        <= '0;
            cnt        <= '0;
            bus.result <= '0;
            bus.valid  <= 1'b0;
`ifdef DIV_BY_SHIFT_SUM_REMAINDER_EN
            bus.remainder <= '0;
`endif
        end else if (bus.start) begin
            dvd       <= bus.a;
            dvs       <= bus.b;
            rem       <= '0;
            quo       <= '0;
            cnt       <= CntW'(WidthD0);
            bus.valid <= 1'b0;
        end else if (step) begin
            dvd <= {dvd[WidthD0-2:0], 1'b0};
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt - CntW'(1);
            if (last) begin
                bus.result <= quo_nxt;
                bus.valid  <= 1'b1;
`ifdef DIV_BY_SHIFT_SUM_REMAINDER_EN
                bus.remainder <= rem_nxt[WidthD1-1:0];
`endif
            end
        end
    end
endmodule

// File: tb/tb_div_by_shift_sum.sv
// Directed checks of div_by_shift_sum at 8/4 and 20/16 widths.
module tb_div_by_shift_sum;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    div_by_shift_sum_if #(.WidthD0(8),  .WidthD1(4))  bus0 ();
    div_by_shift_sum_if #(.WidthD0(20), .WidthD1(16)) bus1 ();

    div_by_shift_sum #(.WidthD0(8),  .WidthD1(4))  dut0 (.clk(clk), .rst(rst), .bus(bus0));
    div_by_shift_sum #(.WidthD0(20), .WidthD1(16)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Start held for 'hold' cycles, then measure edges from release to valid.
    task automatic go0(input logic [7:0] av, input logic [3:0] bv, input int hold, output int lat);
        @(negedge clk);
        bus0.start = 1'b1; bus0.a = av; bus0.b = bv;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("vld_low_in_start", 32'(bus0.valid), 32'd0);
        end
        bus0.start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (bus0.valid) begin lat = i; break; end
        end
    endtask

    task automatic go1(input logic [19:0] av, input logic [15:0] bv, output int lat);
        @(negedge clk);
        bus1.start = 1'b1; bus1.a = av; bus1.b = bv;
        @(negedge clk);
        bus1.start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus1.valid) begin lat = i; break; end
        end
    endtask

    int lat;
    int bad;
    int bl [13] = '{1, 2, 3, 7, 10, 100, 255, 256, 1000, 4096, 12345, 40000, 65535};

    initial begin
        rst = 1'b0;
        bus0.start = 1'b0; bus0.a = '0; bus0.b = '0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0;
        #12;
        chk("rst_result", 32'(bus0.result), 32'd0);
        chk("rst_valid",  32'(bus0.valid),  32'd0);
        @(negedge clk); rst = 1'b1;

        // 142/15 = 9 r 7
        go0(8'd142, 4'd15, 1, lat);
        chk("lat_142_15", 32'(lat), 32'd8);
        chk("res_142_15", 32'(bus0.result), 32'd9);
`ifdef DIV_BY_SHIFT_SUM_REMAINDER_EN
        chk("rem_142_15", 32'(bus0.remainder), 32'd7);
`endif
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            bus0.a = 8'($urandom); bus0.b = 4'($urandom);
            @(negedge clk);
            if (!bus0.valid || bus0.result != 8'd9) bad++;
        end
        chk("hold_20", 32'(bad), 32'd0);

        // start held 5 cycles
        go0(8'd142, 4'd15, 5, lat);
        chk("lat_hold5", 32'(lat), 32'd8);
        chk("res_hold5", 32'(bus0.result), 32'd9);

        go0(8'd200, 4'd0, 1, lat);
        chk("lat_div0", 32'(lat), 32'd8);
        chk("res_div0", 32'(bus0.result), 32'd255);
`ifdef DIV_BY_SHIFT_SUM_REMAINDER_EN
        chk("rem_div0", 32'(bus0.remainder), 32'd8);
`endif

        go0(8'd5, 4'd15, 1, lat);
        chk("res_5_15", 32'(bus0.result), 32'd0);
`ifdef DIV_BY_SHIFT_SUM_REMAINDER_EN
        chk("rem_5_15", 32'(bus0.remainder), 32'd5);
`endif
        go0(8'd255, 4'd1, 1, lat);
        chk("lat_255_1", 32'(lat), 32'd8);
        chk("res_255_1", 32'(bus0.result), 32'd255);

        // restart mid-operation: 142/15 abandoned, 100/7 = 14 r 2
        @(negedge clk);
        bus0.start = 1'b1; bus0.a = 8'd142; bus0.b = 4'd15;
        @(negedge clk);
        bus0.start = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus0.valid || bus0.result != 8'd255) bad++;
        end
        chk("busy_keeps_prev", 32'(bad), 32'd0);
        go0(8'd100, 4'd7, 1, lat);
        chk("lat_restart", 32'(lat), 32'd8);
        chk("res_restart", 32'(bus0.result), 32'd14);
`ifdef DIV_BY_SHIFT_SUM_REMAINDER_EN
        chk("rem_restart", 32'(bus0.remainder), 32'd2);
`endif

        // async reset between edges
        @(negedge clk);
        bus0.start = 1'b1; bus0.a = 8'd142; bus0.b = 4'd15;
        @(negedge clk);
        bus0.start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_result", 32'(bus0.result), 32'd0);
        chk("arst_valid",  32'(bus0.valid),  32'd0);
        @(negedge clk); rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus0.valid) bad++;
        end
        chk("no_valid_after_rst", 32'(bad), 32'd0);

        // wide instance sweep
        foreach (bl[i]) begin
            go1(20'd80000, 16'(bl[i]), lat);
            chk("lat_wide", 32'(lat), 32'd20);
            chk("res_wide", 32'(bus1.result), 32'(80000 / bl[i]));
`ifdef DIV_BY_SHIFT_SUM_REMAINDER_EN
            chk("rem_wide", 32'(bus1.remainder), 32'(80000 % bl[i]));
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
